// File: rtl/pulse_accumulator.sv
// Purpose: sums NCH-lane sample words over a frame of triggered pulses into a RAM, then streams the per-word sums.
// Latency: first sample taken delay+1 clocks after the trigger edge; readout valid 2 clocks after the last captured word.
// Backpressure: valid/ready on the output, word and last flag hold while stalled; acquisition never stalls.
//
// Ports:
//   clk_i, rst_n_i             single clock, async active-low reset (release registered once)
//   enable_i                   run request
//   trig_i                     pulse trigger, rising-edge sensitive
//   din_i                      NCH signed DW-bit samples, lane 0 is the earlier sample
//   cfg_points/pulses/delay_i  words per pulse, pulses per frame, trigger-to-first-sample clocks
//   dout_o/_valid_o/_ready_i   accumulated word stream, dout_last_o marks the final word
//   busy_o                     high outside IDLE
//   overrun_o                  sticky: a trigger edge was ignored
//   frame_cnt_o                completed frames, wrapping
module pulse_accumulator #(
  parameter int DW    = 16,
  parameter int NCH   = 2,
  parameter int DEPTH = 2048,  // must fit in 16 bits
  parameter int ACC_W = 32     // must be >= DW
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 trig_i,
  input  logic [NCH*DW-1:0]    din_i,
  input  logic [15:0]          cfg_points_i,
  input  logic [15:0]          cfg_pulses_i,
  input  logic [15:0]          cfg_delay_i,
  output logic [NCH*ACC_W-1:0] dout_o,
  output logic                 dout_valid_o,
  input  logic                 dout_ready_i,
  output logic                 dout_last_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_DELAY, S_ACQ, S_READOUT} state_t;

  state_t r_state, w_state_nxt;

  logic        r_run;      // FSM held one clock after reset release
  logic        r_trig_d;
  logic [15:0] r_points, r_pulses, r_delay;
  logic [15:0] r_dly_cnt, r_wr_idx, r_pulse_cnt, r_rd_idx, r_frame_cnt;
  logic        r_stop;     // enable dropped during ACQ/READOUT: finish, then idle
  logic        r_overrun;

  // read-modify-write pipeline: capture edge reads RAM, next edge writes the sum
  logic                 r_p_vld, r_p_first;
  logic [AW-1:0]        r_p_addr;
  logic [NCH*DW-1:0]    r_p_din;
  logic [NCH*ACC_W-1:0] r_p_old;
  logic [NCH*ACC_W-1:0] r_mem [DEPTH];

  logic [NCH*ACC_W-1:0] r_dout;
  logic                 r_dout_vld, r_dout_last;

  logic                 w_trig_edge, w_cap, w_last_word, w_last_pulse, w_stop_now;
  logic                 w_out_free, w_xfer, w_rd_go, w_cfg_latch, w_frame_start;
  logic [15:0]          w_pts_clamp, w_pls_clamp;
  logic [NCH*ACC_W-1:0] w_sum;

  assign w_trig_edge   = trig_i & ~r_trig_d;
  assign w_cap         = (r_state == S_ACQ);
  assign w_last_word   = (r_wr_idx == r_points - 16'd1);
  assign w_last_pulse  = (r_pulse_cnt == r_pulses - 16'd1);
  assign w_stop_now    = r_stop | ~enable_i;
  assign w_out_free    = ~r_dout_vld | dout_ready_i;
  assign w_xfer        = r_dout_vld & dout_ready_i;
  // wait out the pending write of the last captured word before reading back
  assign w_rd_go       = (r_state == S_READOUT) & w_out_free & ~r_p_vld & (r_rd_idx < r_points);
  assign w_cfg_latch   = (r_state == S_IDLE) && (w_state_nxt == S_ARM);
  assign w_frame_start = (w_state_nxt == S_ARM) && ((r_state == S_IDLE) || (r_state == S_READOUT));

  assign w_pts_clamp = (cfg_points_i == 16'd0) ? 16'd1 :
                       (cfg_points_i > DEPTH16) ? DEPTH16 : cfg_points_i;
  assign w_pls_clamp = (cfg_pulses_i == 16'd0) ? 16'd1 : cfg_pulses_i;

  // per-lane saturating add; first pulse of a frame ignores stale RAM contents
  for (genvar g = 0; g < NCH; g++) begin : g_lane
    logic [ACC_W:0] w_new, w_old, w_s;
    assign w_new = {{(ACC_W+1-DW){r_p_din[g*DW+DW-1]}}, r_p_din[g*DW +: DW]};
    assign w_old = r_p_first ? '0 : {r_p_old[g*ACC_W+ACC_W-1], r_p_old[g*ACC_W +: ACC_W]};
    assign w_s   = w_new + w_old;
    assign w_sum[g*ACC_W +: ACC_W] =
      (w_s[ACC_W] == w_s[ACC_W-1]) ? w_s[ACC_W-1:0] :
      (w_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_run) begin
      case (r_state)
        S_IDLE:    if (enable_i) w_state_nxt = S_ARM;
        S_ARM: begin
          if (!enable_i)        w_state_nxt = S_IDLE;
          else if (w_trig_edge) w_state_nxt = (r_delay == 16'd0) ? S_ACQ : S_DELAY;
        end
        S_DELAY: begin
          if (!enable_i)                           w_state_nxt = S_IDLE;
          else if (r_dly_cnt == r_delay - 16'd1)   w_state_nxt = S_ACQ;
        end
        S_ACQ: begin
          if (w_last_word) begin
            if (w_last_pulse)    w_state_nxt = S_READOUT;
            else if (w_stop_now) w_state_nxt = S_IDLE;
            else                 w_state_nxt = S_ARM;
          end
        end
        S_READOUT: if (w_xfer && r_dout_last) w_state_nxt = w_stop_now ? S_IDLE : S_ARM;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_run       <= 1'b0;
      r_trig_d    <= 1'b0;
      r_points    <= '0;
      r_pulses    <= '0;
      r_delay     <= '0;
      r_dly_cnt   <= '0;
      r_wr_idx    <= '0;
      r_pulse_cnt <= '0;
      r_rd_idx    <= '0;
      r_frame_cnt <= '0;
      r_stop      <= 1'b0;
      r_overrun   <= 1'b0;
      r_p_vld     <= 1'b0;
      r_p_first   <= 1'b0;
      r_p_addr    <= '0;
      r_p_din     <= '0;
      r_dout      <= '0;
      r_dout_vld  <= 1'b0;
      r_dout_last <= 1'b0;
    end else begin
      r_run    <= 1'b1;
      r_trig_d <= trig_i;
      r_state  <= w_state_nxt;

      if (w_cfg_latch) begin
        r_points <= w_pts_clamp;
        r_pulses <= w_pls_clamp;
        r_delay  <= cfg_delay_i;
      end

      r_dly_cnt <= (r_state == S_DELAY) ? r_dly_cnt + 16'd1 : 16'd0;
      r_wr_idx  <= (w_cap && !w_last_word) ? r_wr_idx + 16'd1 : 16'd0;

      if (w_frame_start)             r_pulse_cnt <= '0;
      else if (w_cap && w_last_word) r_pulse_cnt <= r_pulse_cnt + 16'd1;

      r_stop <= ((r_state == S_ACQ) || (r_state == S_READOUT)) ? w_stop_now : 1'b0;

      if (w_trig_edge && ((r_state == S_DELAY) || (r_state == S_ACQ) || (r_state == S_READOUT)))
        r_overrun <= 1'b1;

      r_p_vld <= w_cap;
      if (w_cap) begin
        r_p_addr  <= r_wr_idx[AW-1:0];
        r_p_din   <= din_i;
        r_p_first <= (r_pulse_cnt == 16'd0);
      end

      if (w_rd_go) begin
        r_dout      <= r_mem[r_rd_idx[AW-1:0]];
        r_dout_vld  <= 1'b1;
        r_dout_last <= (r_rd_idx == r_points - 16'd1);
        r_rd_idx    <= r_rd_idx + 16'd1;
      end else begin
        if (w_xfer) begin
          r_dout_vld  <= 1'b0;
          r_dout_last <= 1'b0;
        end
        if (r_state != S_READOUT) r_rd_idx <= '0;
      end

      if (w_xfer && r_dout_last) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // accumulator RAM: never reset, the first pulse of each frame overwrites
  always_ff @(posedge clk_i) begin
    if (w_cap)   r_p_old <= r_mem[r_wr_idx[AW-1:0]];
    if (r_p_vld) r_mem[r_p_addr] <= w_sum;
  end

  assign dout_o       = r_dout;
  assign dout_valid_o = r_dout_vld;
  assign dout_last_o  = r_dout_last;
  assign busy_o       = (r_state != S_IDLE);
  assign overrun_o    = r_overrun;
  assign frame_cnt_o  = r_frame_cnt;

endmodule

// File: tb/tb_pulse_accumulator.sv
// Directed bench for pulse_accumulator with DW=16, NCH=2, DEPTH=64, ACC_W=18.
module tb_pulse_accumulator;
  localparam int DW = 16, NCH = 2, DEPTH = 64, ACC = 18;

  logic                clk = 1'b0;
  logic                rst_n, enable, trig, dout_ready;
  logic [NCH*DW-1:0]   din;
  logic [15:0]         cfg_points, cfg_pulses, cfg_delay;
  logic [NCH*ACC-1:0]  dout;
  logic                dout_valid, dout_last, busy, overrun;
  logic [15:0]         frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_accumulator #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .ACC_W(ACC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .trig_i(trig), .din_i(din),
    .cfg_points_i(cfg_points), .cfg_pulses_i(cfg_pulses), .cfg_delay_i(cfg_delay),
    .dout_o(dout), .dout_valid_o(dout_valid), .dout_ready_i(dout_ready),
    .dout_last_o(dout_last), .busy_o(busy), .overrun_o(overrun), .frame_cnt_o(frame_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected lane sum: m pulses of the same 16-bit sample, saturated to 18 bits
  function automatic logic [ACC-1:0] lane(input int b, input int s, input int k, input int m);
    logic signed [15:0] v;
    longint             t;
    logic [63:0]        u;
    logic [ACC-1:0]     r;
    v = 16'(b + s * k);
    t = longint'(v) * m;
    u = 64'(t);
    if (t > 131071)       r = 18'h1FFFF;
    else if (t < -131072) r = 18'h20000;
    else                  r = u[ACC-1:0];
    return r;
  endfunction

  // called with the DUT in ARM; extra >= 0 adds a second trigger inside DELAY
  task automatic send_pulse(input int dly, input int nw, input int b0, input int s0,
                            input int b1, input int s1, input int extra);
    trig = 1'b1;
    din  = {16'h0BAD, 16'h0BAD};
    tick();
    trig = 1'b0;
    for (int i = 0; i < dly; i++) begin
      trig = (i == extra);
      tick();
    end
    trig = 1'b0;
    for (int k = 0; k < nw; k++) begin
      din = {16'(b1 + s1 * k), 16'(b0 + s0 * k)};
      tick();
    end
    din = {16'h0BAD, 16'h0BAD};
  endtask

  task automatic read_frame(input int nw, input int m, input int b0, input int s0,
                            input int b1, input int s1, input bit stall, input string tag);
    int                 got, cyc, first_cyc;
    logic [3:0]         pat;
    logic [NCH*ACC-1:0] hold_d, expw;
    logic               hold_l, stalled;
    got = 0; cyc = 0; first_cyc = -1; pat = 4'b1001;
    stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (got < nw && cyc < nw * 4 + 20) begin
      dout_ready = stall ? pat[cyc % 4] : 1'b1;
      if (dout_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (stalled) check({tag, "_hold"}, {dout_last, dout}, {hold_l, hold_d});
        if (dout_ready) begin
          expw = {lane(b1, s1, got, m), lane(b0, s0, got, m)};
          check({tag, "_dat"}, dout, expw);
          check({tag, "_last"}, dout_last, (got == nw - 1));
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d  = dout;
          hold_l  = dout_last;
        end
      end
      tick();
      cyc++;
    end
    dout_ready = 1'b1;
    check({tag, "_count"}, got, nw);
    check({tag, "_first_valid_le2"}, (first_cyc >= 0 && first_cyc <= 2), 1);
    check({tag, "_valid_after"}, dout_valid, 0);
  endtask

  task automatic restart(input int p, input int n, input int d);
    enable = 1'b0;
    tick();
    cfg_points = 16'(p);
    cfg_pulses = 16'(n);
    cfg_delay  = 16'(d);
    enable = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; trig = 1'b0; din = '0; dout_ready = 1'b1;
    cfg_points = 16'd4; cfg_pulses = 16'd3; cfg_delay = 16'd0;
    repeat (3) tick();
    check("rst_valid", dout_valid, 0);
    check("rst_last", dout_last, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_dout", dout, 0);

    // release: no transition on the first edge, IDLE->ARM on the second
    rst_n = 1'b1;
    tick();
    check("rel_edge1_idle", busy, 0);
    tick();
    check("rel_edge2_arm", busy, 1);

    // 4 points, 3 pulses, ramp k+1 on both lanes
    repeat (3) send_pulse(0, 4, 1, 1, 1, 1, -1);
    read_frame(4, 3, 1, 1, 1, 1, 1'b0, "basic");
    check("basic_frame_cnt", frame_cnt, 1);
    check("basic_overrun", overrun, 0);

    // delay 69 with a decoy sample during DELAY and an ignored trigger
    restart(3, 2, 69);
    send_pulse(69, 3, 10, 1, 200, 2, 10);
    check("delay_overrun_set", overrun, 1);
    send_pulse(69, 3, 10, 1, 200, 2, -1);
    read_frame(3, 2, 10, 1, 200, 2, 1'b0, "delay");
    check("delay_frame_cnt", frame_cnt, 2);
    check("delay_overrun_sticky", overrun, 1);

    // saturation both ways; second frame also overwrites stale RAM
    restart(2, 8, 0);
    repeat (8) send_pulse(0, 2, 32767, 0, 32767, 0, -1);
    read_frame(2, 8, 32767, 0, 32767, 0, 1'b0, "sat_pos");
    repeat (8) send_pulse(0, 2, -32768, 0, -32768, 0, -1);
    read_frame(2, 8, -32768, 0, -32768, 0, 1'b0, "sat_neg");
    check("sat_frame_cnt", frame_cnt, 4);

    // ready pattern 1,0,0,1 during readout, negative lane values
    restart(6, 1, 2);
    send_pulse(2, 6, 1, 3, -100, 5, -1);
    read_frame(6, 1, 1, 3, -100, 5, 1'b1, "stall");
    check("stall_frame_cnt", frame_cnt, 5);

    // asynchronous 5 ns reset during ACQ of pulse 2
    restart(4, 3, 0);
    send_pulse(0, 4, 1000, 7, -2000, 3, -1);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    din = {16'(-2000), 16'(1000)};
    tick();
    din = {16'(-1997), 16'(1007)};
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", dout_valid, 0);
    check("arst_overrun", overrun, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    check("arst_dout", dout, 0);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_rel_edge1", busy, 0);
    tick();
    check("arst_rel_edge2", busy, 1);
    repeat (3) send_pulse(0, 4, 1000, 7, -2000, 3, -1);
    read_frame(4, 3, 1000, 7, -2000, 3, 1'b0, "postrst");
    check("postrst_frame_cnt", frame_cnt, 1);

    // points=0 behaves as one word; points beyond DEPTH clamp
    restart(0, 0, 0);
    send_pulse(0, 1, 5, 0, -3, 0, -1);
    read_frame(1, 1, 5, 0, -3, 0, 1'b0, "pts0");
    check("pts0_frame_cnt", frame_cnt, 2);
    restart(5000, 1, 0);
    send_pulse(0, DEPTH, 0, 1, 500, -1, -1);
    read_frame(DEPTH, 1, 0, 1, 500, -1, 1'b0, "clamp");
    check("clamp_frame_cnt", frame_cnt, 3);

    // enable dropped in ARM: idle one clock later
    enable = 1'b0;
    check("drop_busy_before", busy, 1);
    tick();
    check("drop_busy_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
